// File: rtl/uart_receiver.sv
// 16x oversampled UART receiver: start/data/stop framing of the rx pin.
// Optional parity stage is enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int SW = (SB_TICK > 16) ? 5 : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_LAST = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic            r_rx_meta;
    logic            r_rx_s;
    state_t          r_state;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_ferr;

    state_t          w_state_nxt;
    logic [SW-1:0]   w_s_nxt;
    logic [NW-1:0]   w_n_nxt;
    logic [DBIT-1:0] w_b_nxt;
    logic [DBIT-1:0] w_dout_nxt;
    logic            w_done_nxt;
    logic            w_ferr_nxt;

`ifdef UART_RX_PARITY_EN
    logic            r_ppend;
    logic            r_perr;
    logic            w_ppend_nxt;
    logic            w_perr_nxt;
`endif

    // rx is asynchronous; both flops idle high so reset never looks like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_ppend <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
            r_dout  <= w_dout_nxt;
            r_done  <= w_done_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_ppend <= w_ppend_nxt;
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_b_nxt     = r_b;
        w_dout_nxt  = r_dout;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = r_ferr;
`ifdef UART_RX_PARITY_EN
        w_ppend_nxt = r_ppend;
        w_perr_nxt  = r_perr;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = ST_START;
                    w_s_nxt     = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (r_s == S_MID) begin
                        if (!r_rx_s) begin
                            w_state_nxt = ST_DATA;
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_b_nxt = {r_rx_s, r_b[DBIT-1:1]};
                        w_s_nxt = '0;
                        if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = ST_PARITY;
`else
                            w_state_nxt = ST_STOP;
`endif
                        end else begin
                            w_n_nxt = r_n + NW'(1);
                        end
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (r_s == S_LAST) begin
                        w_ppend_nxt = ^r_b ^ r_rx_s ^ 1'(PARITY_ODD);
                        w_s_nxt     = '0;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (r_s == S_STOP) begin
                        w_done_nxt  = 1'b1;
                        w_dout_nxt  = r_b;
                        w_ferr_nxt  = ~r_rx_s;
`ifdef UART_RX_PARITY_EN
                        w_perr_nxt  = r_ppend;
`endif
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rx_done_tick = r_done;
    assign dout         = r_dout;
    assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = r_perr;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames plus random frames and glitches
// checked against a queue of expected bytes built from the framing rules.
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT_LO = 592 + PB * 64;
    localparam int LAT_HI = 640 + PB * 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int tcnt = 0;
    always @(negedge clk) begin
        tcnt   = (tcnt + 1) % 4;
        s_tick = (tcnt == 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk   = 0;
    int n_fail  = 0;
    int n_ticks = 0;
    int n_sent  = 0;

    logic [7:0] q_d[$];
    logic       q_f[$];
    logic       q_p[$];
    int         q_t[$];
    logic [7:0] last_dout = 8'h00;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        int lat;
        if (reset === 1'b1 && rx_done_tick === 1'b1) begin
            n_ticks++;
            if (q_d.size() == 0) begin
                check("spurious_tick", 1, 0);
            end else begin
                lat = cyc - q_t[0];
                check("dout", dout, q_d[0]);
                check("frame_err", frame_err, q_f[0]);
`ifdef UART_RX_PARITY_EN
                check("parity_err", parity_err, q_p[0]);
`endif
                check("latency_window", (lat >= LAT_LO && lat <= LAT_HI), 1);
                last_dout = q_d[0];
                void'(q_d.pop_front());
                void'(q_f.pop_front());
                void'(q_p.pop_front());
                void'(q_t.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic stop_ok,
                        input logic pbit);
        q_d.push_back(d);
        q_f.push_back(!stop_ok);
        q_p.push_back(^d ^ pbit);
        q_t.push_back(cyc);
        n_sent++;
        rx = 1'b0;
        hold(64);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            hold(64);
        end
`ifdef UART_RX_PARITY_EN
        rx = pbit;
        hold(64);
`endif
        if (stop_ok) begin
            rx = 1'b1;
            hold(64);
        end else begin
            rx = 1'b0;
            hold(44);
            rx = 1'b1;
            hold(20);
        end
    endtask

    initial begin
        int t0;
        logic [7:0] d;
        logic ok;
        logic [7:0] aa;
        s_tick = 1'b0;
        reset  = 1'b0;
        rx     = 1'b1;
        hold(5);
        check("rst_dout", dout, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_done", rx_done_tick, 1'b0);
        reset = 1'b1;
        hold(20);

        send(8'h55, 1'b1, 1'b0);
        hold(100);

        t0 = n_ticks;
        rx = 1'b0;
        hold(12);
        rx = 1'b1;
        hold(200);
        check("glitch_no_tick", n_ticks, t0);
        check("glitch_dout", dout, 8'h55);

        send(8'hA5, 1'b0, 1'b0);
        hold(100);
        send(8'h3C, 1'b1, 1'b0);
        hold(100);

        send(8'hF0, 1'b1, 1'b0);
        send(8'h0F, 1'b1, 1'b0);
        hold(100);

        aa = 8'hAA;
        rx = 1'b0;
        hold(64);
        for (int i = 0; i < 4; i++) begin
            rx = aa[i];
            hold(64);
        end
        rx = aa[4];
        hold(32);
        reset = 1'b0;
        #1;
        check("midrst_dout", dout, 8'h00);
        check("midrst_frame_err", frame_err, 1'b0);
        check("midrst_done", rx_done_tick, 1'b0);
        @(negedge clk);
        rx = 1'b1;
        hold(5);
        reset = 1'b1;
        last_dout = 8'h00;
        hold(100);
        send(8'h81, 1'b1, 1'b0);
        hold(100);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        hold(100);
        send(8'h07, 1'b1, 1'b0);
        hold(100);
`endif

        for (int k = 0; k < 40; k++) begin
            d  = 8'($urandom);
            ok = ($urandom % 4) != 0;
            send(d, ok, 1'($urandom));
            if (!ok) hold(64 + $urandom_range(0, 100));
            else     hold($urandom_range(0, 100));
            if ($urandom % 5 == 0) begin
                t0 = n_ticks;
                hold(100);
                rx = 1'b0;
                hold($urandom_range(2, 20));
                rx = 1'b1;
                hold(150);
                check("rand_glitch_no_tick", n_ticks, t0);
            end
        end

        for (int i = 0; i < 2000 && q_d.size() != 0; i++) @(negedge clk);
        check("drain", q_d.size(), 0);
        check("tick_count", n_ticks, n_sent);
        check("final_dout", dout, last_dout);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
